spi_boot_command: RTL
=====================

Name: spi_boot_command

Overview:
Host-facing SPI slave command decoder for the factory boot image. It receives frames from the host MCU on the FPGA SPI pins, oversampled on the 25 MHz system clock. It drives the flash bypass enable and issues reconfiguration requests (image address) to the remote-update sequencer directly downstream. It also returns a status byte on MISO.

Parameters:
SYNC_STAGES, 2, synchroniser depth for sclk/mosi/cs_n (min 2)
ADDR_MAX, 24'hFFFFFF, highest accepted image address; larger addresses are rejected as checksum/range error

Ports:
clock  in  1  system clock, 25 MHz
reset  in  1  synchronous, active-high reset
spi_sclk  in  1  host SPI clock, mode 0; max frequency clock/8
spi_mosi  in  1  host data, MSB first
spi_cs_n  in  1  host chip select, active low
spi_miso  out  1  status data out
spi_miso_oe  out  1  MISO output enable; top level tri-states when 0
rsu_trigger  in  5  trigger condition bits from the update sequencer, reported in status
bypass  out  1  sticky flash-bypass enable
req_valid  out  1  reconfiguration request pending
req_ready  in  1  downstream accepts request
req_addr  out  24  image start address for the request

Behaviour:
- Reset: bypass=0, req_valid=0, req_addr=0, spi_miso=0, spi_miso_oe=0, error flags=0, FSM=IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised signals: sclk rise (sample), sclk fall (shift out), cs fall, cs rise.
- FSM states:
  - IDLE: on cs fall, go to ACTIVE. Clear the bit counter (3 b) and byte counter (3 b, saturates at 7). Latch status byte into the shift-out register, drive spi_miso=status[7], set spi_miso_oe=1.
  - ACTIVE: on each sclk rise, shift MOSI into rx byte. When the 8th bit arrives, store the byte at the byte index (indices 0..4 kept, later bytes dropped) and increment the byte counter. On each sclk fall, shift the next status bit out. After 8 bits, MISO=0. On cs rise, set oe=0 and go to DECODE.
  - DECODE: one cycle. Evaluate the frame, then go to IDLE.
- Frame decode runs only when the bit counter==0 at cs rise (whole bytes). Otherwise set err_length and take no action.
  - 0x9A, length 1: bypass<=1.
  - 0xA5, length 5, bytes {cmd,a2,a1,a0,chk}:
    - chk must equal ~(cmd^a2^a1^a0) and addr must be ≤ADDR_MAX; otherwise set err_checksum.
    - If req_valid is already 1, set err_busy and drop the request.
    - Otherwise req_addr<={a2,a1,a0}, req_valid<=1.
  - 0x5A, length 1: clear all error flags (after the status byte already shifted out this frame).
  - Any other opcode or length: set err_length.
- While bypass=1, every frame is ignored: no decode, oe stays 0. Host traffic is then flash traffic. Only reset clears bypass.
- Request handshake: req_valid is held and req_addr stays stable until the cycle where req_valid&req_ready, then it clears next cycle. A new valid request in DECODE in the same cycle as acceptance is accepted (valid stays 1, address updates).
- Status byte: {bypass, req_valid, err_checksum, err_busy, err_length, rsu_trigger[3], rsu_trigger[1], rsu_trigger[0]}, latched at cs fall.
- Reset mid-frame: the frame is abandoned and outputs return to reset values. The remaining host clocks are ignored until the next cs fall.
- cs rise with zero bytes: no action, no error.

Decomposition:
- Package spi_boot_pkg: opcode constants (CMD_BYPASS=8'h9A, CMD_RECONFIG=8'hA5, CMD_STATUS=8'h5A), frame lengths, FSM state enum, status bit index constants.
- One sub-module, spi_slave_sync: synchroniser plus edge detect for sclk/cs_n and delayed mosi, outputs sample/shift/cs_fall/cs_rise strobes.
- Decoder FSM and handshake stay in spi_boot_command.

Test Plan:
- Reconfig: frame A5 10 00 00 4A, req_ready=0 → req_valid=1 and req_addr=24'h100000 after DECODE. Raise req_ready → req_valid=0 next cycle.
- Bad checksum: A5 10 00 00 00 → no req_valid. Next frame's status byte has bit5=1. Frame 5A clears it; the following status shows bit5=0.
- Busy: two valid A5 frames with req_ready=0 → first address retained, err_busy=1 (status bit4).
- Abort: cs_n raised after 12 bits of an A5 frame → no request, err_length=1.
- Bypass: frame 9A → bypass=1. A subsequent A5 frame produces no request, and spi_miso_oe stays 0 throughout.
- Reset mid-frame: assert reset during byte 2 of an A5 frame, then send a clean A5 frame → only the clean frame yields a request. rsu_trigger=5'b00001 → status bit0=1.

Source files
------------

// File: rtl/spi_boot_pkg.sv
// Shared constants and types for the factory-boot SPI command decoder.
// Opcodes, frame lengths, FSM encoding and status-byte bit positions.
package spi_boot_pkg;

    localparam logic [7:0] CMD_BYPASS   = 8'h9A;
    localparam logic [7:0] CMD_RECONFIG = 8'hA5;
    localparam logic [7:0] CMD_STATUS   = 8'h5A;

    localparam logic [2:0] LEN_BYPASS   = 3'd1;
    localparam logic [2:0] LEN_RECONFIG = 3'd5;
    localparam logic [2:0] LEN_STATUS   = 3'd1;
    localparam logic [2:0] NUM_BYTES    = 3'd5;

    localparam int STAT_BYPASS    = 7;
    localparam int STAT_REQ_VALID = 6;
    localparam int STAT_ERR_CHK   = 5;
    localparam int STAT_ERR_BUSY  = 4;
    localparam int STAT_ERR_LEN   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    function automatic logic [7:0] reconfig_chk(input logic [7:0] cmd, input logic [7:0] a2,
                                                input logic [7:0] a1, input logic [7:0] a0);
        return ~(cmd ^ a2 ^ a1 ^ a0);
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings the host SPI pins into the system clock domain and turns them into
// single-cycle strobes: sample (sclk rise), shift (sclk fall), cs fall, cs rise.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_n_i,
    output logic sample_o,
    output logic shift_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] cs_n_q;
    logic                   sclk_prev_q;
    logic                   cs_n_prev_q;

    // cs_n resets as "selected" so a host still mid-frame when reset drops does
    // not produce a fake falling edge; only a genuine new cs fall starts a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_q      <= '0;
            mosi_q      <= '0;
            cs_n_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            cs_n_q      <= {cs_n_q[SYNC_STAGES-2:0], cs_n_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            cs_n_prev_q <= cs_n_q[SYNC_STAGES-1];
        end
    end

    assign sample_o  =  sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign shift_o   = ~sclk_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign cs_fall_o = ~cs_n_q[SYNC_STAGES-1] &  cs_n_prev_q;
    assign cs_rise_o =  cs_n_q[SYNC_STAGES-1] & ~cs_n_prev_q;
    // mosi has the same depth as sclk, so it is aligned with the sample strobe.
    assign mosi_o    =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_boot_command.sv
// SPI slave command decoder for the factory boot image: collects a frame,
// decodes bypass / reconfigure / status-clear, and shifts a status byte out.
module spi_boot_command #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] ADDR_MAX    = 24'hFFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [4:0]  rsu_trigger,
    output logic        bypass,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [23:0] req_addr
);

    import spi_boot_pkg::*;

    logic sample, shift, cs_fall, cs_rise, mosi_s;

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .sclk_i    (spi_sclk),
        .mosi_i    (spi_mosi),
        .cs_n_i    (spi_cs_n),
        .sample_o  (sample),
        .shift_o   (shift),
        .cs_fall_o (cs_fall),
        .cs_rise_o (cs_rise),
        .mosi_o    (mosi_s)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  frame_q [NUM_BYTES];
    logic [7:0]  frame_d [NUM_BYTES];
    logic [7:0]  tx_q, tx_d;
    logic        oe_q, oe_d;
    logic        bypass_q, bypass_d;
    logic        req_valid_q, req_valid_d;
    logic [23:0] req_addr_q, req_addr_d;
    logic        err_chk_q, err_chk_d;
    logic        err_busy_q, err_busy_d;
    logic        err_len_q, err_len_d;

    logic [7:0]  status;
    logic [23:0] frame_addr;
    logic        addr_ok;
    logic        chk_ok;
    logic        trig_unused;

    // rsu_trigger[4] and [2] are not part of the status byte.
    assign trig_unused = rsu_trigger[4] ^ rsu_trigger[2];

    always_comb begin
        status                 = '0;
        status[STAT_BYPASS]    = bypass_q;
        status[STAT_REQ_VALID] = req_valid_q;
        status[STAT_ERR_CHK]   = err_chk_q;
        status[STAT_ERR_BUSY]  = err_busy_q;
        status[STAT_ERR_LEN]   = err_len_q;
        status[2:0]            = {rsu_trigger[3], rsu_trigger[1], rsu_trigger[0]};
    end

    assign frame_addr = {frame_q[1], frame_q[2], frame_q[3]};
    assign addr_ok    = ({1'b0, frame_addr} <= {1'b0, ADDR_MAX});
    assign chk_ok     = (frame_q[4] == reconfig_chk(frame_q[0], frame_q[1], frame_q[2], frame_q[3]));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_q        <= '0;
            frame_q     <= '{default: 8'h00};
            tx_q        <= '0;
            oe_q        <= 1'b0;
            bypass_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            err_chk_q   <= 1'b0;
            err_busy_q  <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            frame_q     <= frame_d;
            tx_q        <= tx_d;
            oe_q        <= oe_d;
            bypass_q    <= bypass_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            err_chk_q   <= err_chk_d;
            err_busy_q  <= err_busy_d;
            err_len_q   <= err_len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        frame_d     = frame_q;
        tx_d        = tx_q;
        oe_d        = oe_q;
        bypass_d    = bypass_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        err_chk_d   = err_chk_q;
        err_busy_d  = err_busy_q;
        err_len_d   = err_len_q;

        if (req_valid_q && req_ready) begin
            req_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // In bypass the host is talking to the flash; stay silent.
                if (cs_fall && !bypass_q) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    tx_d       = status;
                    oe_d       = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    oe_d    = 1'b0;
                    tx_d    = '0;
                    state_d = ST_DECODE;
                end else begin
                    if (sample) begin
                        rx_d      = {rx_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q < NUM_BYTES) begin
                                frame_d[byte_cnt_q] = rx_d;
                            end
                            if (byte_cnt_q != 3'd7) begin
                                byte_cnt_d = byte_cnt_q + 3'd1;
                            end
                        end
                    end
                    // Zero fill means MISO reads 0 once the status byte is out.
                    if (shift) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (bit_cnt_q != 3'd0) begin
                    err_len_d = 1'b1;
                end else if (byte_cnt_q != 3'd0) begin
                    case (frame_q[0])
                        CMD_BYPASS: begin
                            if (byte_cnt_q == LEN_BYPASS) bypass_d  = 1'b1;
                            else                          err_len_d = 1'b1;
                        end
                        CMD_RECONFIG: begin
                            if (byte_cnt_q != LEN_RECONFIG) begin
                                err_len_d = 1'b1;
                            end else if (!chk_ok || !addr_ok) begin
                                err_chk_d = 1'b1;
                            end else if (req_valid_q && !req_ready) begin
                                err_busy_d = 1'b1;
                            end else begin
                                req_valid_d = 1'b1;
                                req_addr_d  = frame_addr;
                            end
                        end
                        CMD_STATUS: begin
                            if (byte_cnt_q == LEN_STATUS) begin
                                err_chk_d  = 1'b0;
                                err_busy_d = 1'b0;
                                err_len_d  = 1'b0;
                            end else begin
                                err_len_d = 1'b1;
                            end
                        end
                        default: err_len_d = 1'b1;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign spi_miso    = tx_q[7];
    assign spi_miso_oe = oe_q;
    assign bypass      = bypass_q;
    assign req_valid   = req_valid_q;
    assign req_addr    = req_addr_q;

endmodule
